cdb_complete_arbiter: RTL and testbench
=======================================

# cdb_complete_arbiter

Completion-slot arbiter that sits directly upstream of the execute stage and drives its CDB select inputs. Each cycle it assigns the `N` CDB slots to functional units that have a result ready. Single-cycle ALU and branch results always win. Multi-cycle mult and load/store results, which hold until granted, share the remaining slots round-robin. An optional starvation guard throttles single-cycle issue so that a waiting multi-cycle result is guaranteed a slot.

## Interface
Parameters:
- `N`, default `` `N ``: CDB width (completion slots per cycle).
- `NUM_MULT`, default `` `NUM_FU_MULT ``: mult FUs.
- `NUM_LDST`, default `` `NUM_FU_LDST ``: load/store FUs.
- `NUM_ALU`, default `` `NUM_FU_ALU ``: ALU FUs.
- `NUM_BRANCH`, default `` `NUM_FU_BRANCH ``: branch FUs.
- `STARVE_LIMIT`, default 4: consecutive denied cycles before a multi-cycle FU is marked starving.
- `RESERVE_MAX`, default 1: maximum slots reserved for starving FUs (must be ≤ `N`).

Ports (clock and reset first). `TOT = NUM_MULT+NUM_LDST+NUM_ALU+NUM_BRANCH`; `M = NUM_MULT+NUM_LDST`.
- `clock` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `mult_cdb_valid` in `NUM_MULT`: mult result held and waiting.
- `ldst_cdb_valid` in `NUM_LDST`: ldst result held and waiting.
- `alu_req` in `NUM_ALU`: valid bits of the registered ALU packets completing this cycle.
- `branch_req` in `NUM_BRANCH`: valid bits of the registered branch packets completing this cycle.
- `complete_gnt_bus` out `[N][TOT]`: one-hot-or-zero FU select per slot.
- `mult_cdb_en` out `NUM_MULT`: mult FU granted this cycle.
- `ldst_cdb_en` out `NUM_LDST`: ldst FU granted this cycle.
- `fixed_issue_limit` out `$clog2(N+1)`: maximum ALU+branch ops the issue stage may dispatch this cycle.
- `overcommit` out 1: sticky error flag; fixed requests exceeded `N`.

## Operation
- FU index order in `complete_gnt_bus[i][j]`:
  - mult: `0..NUM_MULT-1`
  - ldst: next `NUM_LDST` indices
  - ALU: next `NUM_ALU` indices
  - branch: last `NUM_BRANCH` indices
- Multi-cycle index `k` (`0..M-1`) equals FU index `j`.
- Fixed grants:
  - Every asserted `alu_req`/`branch_req` is granted, filling slots 0 upward in ascending FU index.
  - If the fixed request count exceeds `N`, the first `N` are granted and `overcommit` is set (sticky until reset).
- Multi grants:
  - Free slots = `N` minus the number of fixed grants.
  - Candidates are searched circularly starting at `rr_ptr`.
  - Pass 1 takes starving requesters; pass 2 takes the remaining requesters. Both passes use circular order.
  - Granted candidates fill the free slots in ascending slot order.
- `mult_cdb_en[k]` / `ldst_cdb_en[k]` = OR over slots of that FU's grant column.
- `rr_ptr` (`$clog2(M)` bits):
  - On a clock edge with ≥1 multi grant: `rr_ptr <= (last granted k in search order + 1) mod M`.
  - Otherwise: unchanged.
- Starvation counter per multi FU (width `$clog2(STARVE_LIMIT+1)`):
  - Increments when the FU requests and is not granted; saturates at `STARVE_LIMIT`.
  - Clears when the FU is granted or its request is low.
  - Starving means counter == `STARVE_LIMIT`.
- `fixed_issue_limit = N - min(#starving, RESERVE_MAX)`.
- Squash: a squashed mult drops its valid, which clears its counter next edge. No branch-mask input is needed.

## Timing
- Grants and enables are combinational from same-cycle requests and current state; there is zero latency to `complete_gnt_bus`.
- `fixed_issue_limit` is combinational from registered counters:
  - It applies to issue at cycle t; those ops request at t+1.
  - Because a multi-cycle FU holds its valid until granted, a starving FU at t is still requesting at t+1 and receives a reserved slot.
- Reset (asynchronous, while `reset_n` = 0):
  - `rr_ptr` = 0, all counters = 0, `overcommit` = 0.
  - All grants and enables forced to 0.
  - `fixed_issue_limit` = `N`.
- Reset mid-operation drops pending arbitration state. Grants resume on the first edge after `reset_n` rises.
- A request and grant in the same cycle: the FU must deassert valid the following cycle unless it has a new result.
- `M` = 1: `rr_ptr` is held at 0.

## Configuration
- `CDB_STARVE_GUARD_EN` defined:
  - Starvation counters, pass-1 priority and reservation are present as described.
- `CDB_STARVE_GUARD_EN` undefined:
  - No counters or pass 1; multi grants use round-robin only.
  - `fixed_issue_limit` is constant `N`.
  - `STARVE_LIMIT` and `RESERVE_MAX` are ignored.

## Test plan
All scenarios use `N`=2, `NUM_MULT`=2, `NUM_LDST`=1, `NUM_ALU`=2, `NUM_BRANCH`=1 (FU index: mult 0–1, ldst 2, ALU 3–4, branch 5).
- Reset: with `reset_n` low and all requests high → all grants 0 and `fixed_issue_limit`=2. After `reset_n` rises, `rr_ptr`=0.
- Fixed priority: `alu_req`=11 and `mult_cdb_valid`=01 → slot0 = FU3, slot1 = FU4, `mult_cdb_en`=00.
- Round-robin: `mult_cdb_valid`=11 and `ldst_cdb_valid`=1 held, no fixed requests, over 3 cycles → grants {0,1}, {2,0}, {1,2}.
- Starvation (guard on): `alu_req`=11 every cycle, `mult_cdb_valid`=01 held → `fixed_issue_limit` drops to 1 after 4 denied cycles. The bench obeys the limit, so the next cycle grants FU0 and the counter clears.
- Starvation (guard off): same stimulus → `fixed_issue_limit` stays 2 and FU0 is never granted.
- Overcommit: `alu_req`=11 and `branch_req`=1 → slots get FU3 and FU4, `overcommit`=1. It stays 1 until `reset_n` is asserted.

Source files
------------

// File: rtl/cdb_complete_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_complete_arbiter: CDB completion-slot arbiter (fixed-priority ALU/branch,
// round-robin mult/ldst). Optional starvation guard: CDB_STARVE_GUARD_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef N
`define N 2
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 2
`endif
`ifndef NUM_FU_LDST
`define NUM_FU_LDST 1
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif
`ifndef NUM_FU_BRANCH
`define NUM_FU_BRANCH 1
`endif

module cdb_complete_arbiter #(
  parameter int N            = `N,
  parameter int NUM_MULT     = `NUM_FU_MULT,
  parameter int NUM_LDST     = `NUM_FU_LDST,
  parameter int NUM_ALU      = `NUM_FU_ALU,
  parameter int NUM_BRANCH   = `NUM_FU_BRANCH,
  parameter int STARVE_LIMIT = 4,
  parameter int RESERVE_MAX  = 1,
  localparam int M   = NUM_MULT + NUM_LDST,
  localparam int F   = NUM_ALU + NUM_BRANCH,
  localparam int TOT = M + F,
  localparam int PW  = (M > 1) ? $clog2(M) : 1,
  localparam int LW  = $clog2(N + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_MULT-1:0]     mult_cdb_valid,
  input  logic [NUM_LDST-1:0]     ldst_cdb_valid,
  input  logic [NUM_ALU-1:0]      alu_req,
  input  logic [NUM_BRANCH-1:0]   branch_req,
  output logic [N-1:0][TOT-1:0]   complete_gnt_bus,
  output logic [NUM_MULT-1:0]     mult_cdb_en,
  output logic [NUM_LDST-1:0]     ldst_cdb_en,
  output logic [LW-1:0]           fixed_issue_limit,
  output logic                    overcommit
);

  generate
    if (RESERVE_MAX > N) begin : g_bad_reserve
      $error("RESERVE_MAX must not exceed N");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be at least 1");
    end
  endgenerate

  logic [M-1:0]         multi_req;
  logic [F-1:0]         fixed_req;
  logic [M-1:0]         starving;
  logic [M-1:0]         multi_gnt;
  logic [N-1:0][TOT-1:0] gnt;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        rr_next;
  logic                 rr_adv;
  logic                 over_now;
  logic                 over_q;
  int                   slot;
  int                   fixed_cnt;
  int                   idx;
  int                   last;
  int                   nxt;

  assign multi_req = {ldst_cdb_valid, mult_cdb_valid};
  assign fixed_req = {branch_req, alu_req};

  // Constant-index writes only: the dynamic slot/candidate positions are
  // matched against unrolled loop indices.
  always_comb begin
    gnt       = '0;
    multi_gnt = '0;
    slot      = 0;
    fixed_cnt = 0;
    idx       = 0;
    last      = 0;
    nxt       = 0;
    rr_adv    = 1'b0;
    for (int j = 0; j < F; j++) begin
      if (fixed_req[j]) begin
        for (int s = 0; s < N; s++)
          if (s == slot) gnt[s][M+j] = 1'b1;
        if (slot < N) slot = slot + 1;
        fixed_cnt = fixed_cnt + 1;
      end
    end
    over_now = (fixed_cnt > N);
    // Pass 0 takes starving requesters, pass 1 everything still pending.
    for (int p = 0; p < 2; p++) begin
      for (int off = 0; off < M; off++) begin
        idx = int'(rr_ptr) + off;
        if (idx >= M) idx = idx - M;
        for (int k = 0; k < M; k++) begin
          if (k == idx && multi_req[k] && !multi_gnt[k] &&
              (p == 1 || starving[k]) && slot < N) begin
            for (int s = 0; s < N; s++)
              if (s == slot) gnt[s][k] = 1'b1;
            multi_gnt[k] = 1'b1;
            slot         = slot + 1;
            last         = k;
            rr_adv       = 1'b1;
          end
        end
      end
    end
    nxt = last + 1;
    if (nxt >= M) nxt = 0;
    rr_next = PW'(nxt);
  end

  assign complete_gnt_bus = reset_n ? gnt : '0;
  assign mult_cdb_en      = reset_n ? multi_gnt[NUM_MULT-1:0] : '0;
  assign ldst_cdb_en      = reset_n ? multi_gnt[M-1:NUM_MULT] : '0;
  assign overcommit       = reset_n & (over_q | over_now);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      over_q <= 1'b0;
    end else begin
      if (rr_adv && M > 1) rr_ptr <= rr_next;
      over_q <= over_q | over_now;
    end
  end

`ifdef CDB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [M-1:0][CW-1:0] starve_cnt;
  int                   n_starve;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else begin
      for (int k = 0; k < M; k++) begin
        if (multi_req[k] && !multi_gnt[k]) begin
          if (starve_cnt[k] != CW'(STARVE_LIMIT))
            starve_cnt[k] <= starve_cnt[k] + CW'(1);
        end else begin
          starve_cnt[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    starving = '0;
    n_starve = 0;
    for (int k = 0; k < M; k++) begin
      starving[k] = (starve_cnt[k] == CW'(STARVE_LIMIT));
      if (starving[k]) n_starve = n_starve + 1;
    end
    fixed_issue_limit = LW'(N - ((n_starve < RESERVE_MAX) ? n_starve : RESERVE_MAX));
  end
`else
  assign starving          = '0;
  assign fixed_issue_limit = LW'(N);
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_complete_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_complete_arbiter: directed bench with a queue-based reference model
// of the slot assignment rules plus literal spot checks. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cdb_complete_arbiter;

  localparam int TN   = 2;
  localparam int TMU  = 2;
  localparam int TLS  = 1;
  localparam int TAL  = 2;
  localparam int TBR  = 1;
  localparam int TM   = TMU + TLS;
  localparam int TF   = TAL + TBR;
  localparam int TTOT = TM + TF;
  localparam int SL   = 4;
  localparam int RM   = 1;

  logic                  clock;
  logic                  reset_n;
  logic [TMU-1:0]        mult_cdb_valid;
  logic [TLS-1:0]        ldst_cdb_valid;
  logic [TAL-1:0]        alu_req;
  logic [TBR-1:0]        branch_req;
  logic [TN-1:0][TTOT-1:0] complete_gnt_bus;
  logic [TMU-1:0]        mult_cdb_en;
  logic [TLS-1:0]        ldst_cdb_en;
  logic [1:0]            fixed_issue_limit;
  logic                  overcommit;

  int tests = 0;
  int fails = 0;

  cdb_complete_arbiter #(
    .N(TN), .NUM_MULT(TMU), .NUM_LDST(TLS), .NUM_ALU(TAL), .NUM_BRANCH(TBR),
    .STARVE_LIMIT(SL), .RESERVE_MAX(RM)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .mult_cdb_valid   (mult_cdb_valid),
    .ldst_cdb_valid   (ldst_cdb_valid),
    .alu_req          (alu_req),
    .branch_req       (branch_req),
    .complete_gnt_bus (complete_gnt_bus),
    .mult_cdb_en      (mult_cdb_en),
    .ldst_cdb_en      (ldst_cdb_en),
    .fixed_issue_limit(fixed_issue_limit),
    .overcommit       (overcommit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model state (committed on posedge) and its pending next values.
  int m_rr = 0;
  int m_cnt [TM] = '{default: 0};
  bit m_ovc = 0;
  int n_rr = 0;
  int n_cnt [TM] = '{default: 0};
  bit n_ovc = 0;

  logic [TTOT-1:0] e_slot [TN];
  logic [TM-1:0]   e_mg;
  int              e_lim;
  bit              e_ovc;
  int              fq[$];
  int              cand[$];

  function automatic bit is_starving(input int k);
`ifdef CDB_STARVE_GUARD_EN
    return m_cnt[k] == SL;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clock) begin : model
    logic [TF-1:0] fr;
    logic [TM-1:0] mr;
    int used, last, nst, k;
    bit any;
    fr = {branch_req, alu_req};
    mr = {ldst_cdb_valid, mult_cdb_valid};
    for (int s = 0; s < TN; s++) e_slot[s] = '0;
    e_mg = '0;
    if (!reset_n) begin
      e_lim = TN;
      e_ovc = 1'b0;
      n_rr  = 0;
      n_ovc = 1'b0;
      for (int i = 0; i < TM; i++) n_cnt[i] = 0;
    end else begin
      fq.delete();
      cand.delete();
      for (int j = 0; j < TF; j++) if (fr[j]) fq.push_back(TM + j);
      used = 0;
      foreach (fq[i]) if (used < TN) begin e_slot[used][fq[i]] = 1'b1; used++; end
      e_ovc = m_ovc || (fq.size() > TN);
      for (int off = 0; off < TM; off++) begin
        k = (m_rr + off) % TM;
        if (mr[k] && is_starving(k)) cand.push_back(k);
      end
      for (int off = 0; off < TM; off++) begin
        k = (m_rr + off) % TM;
        if (mr[k] && !is_starving(k)) cand.push_back(k);
      end
      any = 0;
      last = 0;
      foreach (cand[i]) if (used < TN) begin
        e_slot[used][cand[i]] = 1'b1;
        e_mg[cand[i]] = 1'b1;
        used++;
        last = cand[i];
        any = 1;
      end
      n_rr = any ? (last + 1) % TM : m_rr;
      for (int i = 0; i < TM; i++)
        n_cnt[i] = (mr[i] && !e_mg[i]) ? ((m_cnt[i] + 1 > SL) ? SL : m_cnt[i] + 1) : 0;
      nst = 0;
      for (int i = 0; i < TM; i++) if (is_starving(i)) nst++;
      e_lim = TN - ((nst < RM) ? nst : RM);
      n_ovc = e_ovc;
    end
    check("model_slot0", complete_gnt_bus[0], e_slot[0]);
    check("model_slot1", complete_gnt_bus[1], e_slot[1]);
    check("model_mult_en", mult_cdb_en, e_mg[TMU-1:0]);
    check("model_ldst_en", ldst_cdb_en, e_mg[TM-1:TMU]);
    check("model_limit", fixed_issue_limit, e_lim);
    check("model_overcommit", overcommit, e_ovc);
  end

  always @(posedge clock) begin
    m_rr  = n_rr;
    m_ovc = n_ovc;
    for (int i = 0; i < TM; i++) m_cnt[i] = n_cnt[i];
  end

  // Apply one cycle of stimulus just after posedge, return just after negedge.
  task automatic step(input logic r, input logic [1:0] m, input logic l,
                      input logic [1:0] a, input logic b);
    @(posedge clock);
    #1;
    reset_n = r;
    mult_cdb_valid = m;
    ldst_cdb_valid = l;
    alu_req = a;
    branch_req = b;
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    mult_cdb_valid = '0;
    ldst_cdb_valid = '0;
    alu_req = '0;
    branch_req = '0;

    step(0, 2'b11, 1, 2'b11, 1);
    check("rst_slot0", complete_gnt_bus[0], 0);
    check("rst_slot1", complete_gnt_bus[1], 0);
    check("rst_mult_en", mult_cdb_en, 0);
    check("rst_ldst_en", ldst_cdb_en, 0);
    check("rst_limit", fixed_issue_limit, 2);
    check("rst_overcommit", overcommit, 0);
    step(0, 2'b11, 1, 2'b11, 1);

    step(1, 2'b01, 0, 2'b11, 0);
    check("fixed_slot0", complete_gnt_bus[0], 6'h08);
    check("fixed_slot1", complete_gnt_bus[1], 6'h10);
    check("fixed_mult_en", mult_cdb_en, 0);

    step(1, 2'b11, 1, 2'b00, 0);
    check("rr1_slot0", complete_gnt_bus[0], 6'h01);
    check("rr1_slot1", complete_gnt_bus[1], 6'h02);
    step(1, 2'b11, 1, 2'b00, 0);
    check("rr2_slot0", complete_gnt_bus[0], 6'h04);
    check("rr2_slot1", complete_gnt_bus[1], 6'h01);
    step(1, 2'b11, 1, 2'b00, 0);
    check("rr3_slot0", complete_gnt_bus[0], 6'h02);
    check("rr3_slot1", complete_gnt_bus[1], 6'h04);
    check("rr3_ldst_en", ldst_cdb_en, 1);

    step(1, 2'b00, 0, 2'b00, 0);
    check("idle_mult_en", mult_cdb_en, 0);

    step(1, 2'b00, 1, 2'b01, 1);
    check("mix_slot0", complete_gnt_bus[0], 6'h08);
    check("mix_slot1", complete_gnt_bus[1], 6'h20);
    check("mix_ldst_en", ldst_cdb_en, 0);
    check("mix_overcommit", overcommit, 0);

    for (int i = 1; i <= 5; i++) begin
      step(1, 2'b01, 0, 2'b11, 0);
      check("starve_mult_en", mult_cdb_en, 0);
`ifdef CDB_STARVE_GUARD_EN
      check("starve_limit", fixed_issue_limit, (i == 5) ? 1 : 2);
`else
      check("starve_limit", fixed_issue_limit, 2);
`endif
    end
`ifdef CDB_STARVE_GUARD_EN
    step(1, 2'b01, 0, 2'b01, 0);
    check("reserve_slot0", complete_gnt_bus[0], 6'h08);
    check("reserve_slot1", complete_gnt_bus[1], 6'h01);
    check("reserve_mult_en", mult_cdb_en, 2'b01);
`else
    step(1, 2'b01, 0, 2'b11, 0);
    check("noguard_mult_en", mult_cdb_en, 0);
    check("noguard_limit", fixed_issue_limit, 2);
`endif
    step(1, 2'b00, 0, 2'b11, 0);
    check("post_starve_limit", fixed_issue_limit, 2);

    step(1, 2'b00, 0, 2'b11, 1);
    check("ovc_slot0", complete_gnt_bus[0], 6'h08);
    check("ovc_slot1", complete_gnt_bus[1], 6'h10);
    check("ovc_flag", overcommit, 1);
    step(1, 2'b00, 0, 2'b00, 0);
    check("ovc_sticky", overcommit, 1);
    step(0, 2'b11, 1, 2'b11, 1);
    check("midrst_overcommit", overcommit, 0);
    check("midrst_slot0", complete_gnt_bus[0], 0);
    check("midrst_limit", fixed_issue_limit, 2);
    step(1, 2'b00, 0, 2'b00, 0);
    check("postrst_overcommit", overcommit, 0);
    step(1, 2'b11, 1, 2'b00, 0);
    check("postrst_rr_slot0", complete_gnt_bus[0], 6'h01);
    check("postrst_rr_slot1", complete_gnt_bus[1], 6'h02);
    step(1, 2'b00, 0, 2'b00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
